player_draw_ctrl: RTL and testbench

Per-frame sequencer for the player sprite, feeding the VGA adapter's plot port alongside the obstacle path. On each frame tick it erases the 4×4 player sprite at its old position, moves it one step right (and up/down from the keys), redraws it, then checks for collision with the obstacle and for reaching the finish column. It owns the `draw` / `setoff` pacing that the pixel datapath previously derived from free-running counters. It exposes a clean plot stream and status flags to the top-level FSM.

---
 rtl/dodger_pkg.sv | 23 ++
 rtl/sprite_walker.sv | 31 +++
 rtl/player_draw_ctrl.sv | 135 +++++++++++++
 tb/tb_player_draw_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dodger_pkg.sv
// Shared types and constants for the dodger game: sequencer states, sprite and
// screen geometry, and the colour codes written to the VGA adapter.
package dodger_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ERASE,
    ST_MOVE,
    ST_DRAW,
    ST_CHECK,
    ST_OVER
  } state_t;

  localparam int SPRITE_W = 4;
  localparam int SPRITE_H = 4;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'd0;
  localparam logic [2:0] GREEN = 3'd2;

endpackage

// File: rtl/sprite_walker.sv
// Walks the 16 pixel offsets of a 4x4 sprite while start is held high;
// done flags the last offset so the owner can leave its walking state.
module sprite_walker
  import dodger_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] dx,
  output logic [1:0] dy,
  output logic       done
);

  localparam int CNT_W = $clog2(SPRITE_W * SPRITE_H);

  logic [CNT_W-1:0] cnt;

  // Wraps 15 -> 0 on its own, so the next walk always starts at offset 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dx   = cnt[1:0];
  assign dy   = cnt[3:2];
  assign done = start && (cnt == '1);

endmodule

// File: rtl/player_draw_ctrl.sv
// Per-frame player sprite sequencer: erase, move, redraw, then collision and
// finish check, producing a registered plot stream and sticky status flags.
module player_draw_ctrl
  import dodger_pkg::*;
#(
  parameter logic [7:0] START_X       = 8'd10,
  parameter logic [6:0] START_Y       = 7'd58,
  parameter logic [7:0] X_LIMIT       = 8'd100,
  parameter logic [6:0] Y_MAX         = 7'd116,
  parameter logic [2:0] PLAYER_COLOUR = GREEN,
  parameter logic [2:0] BG_COLOUR     = BLACK
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [7:0] obs_x,
  input  logic [6:0] obs_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       game_over,
  output logic       won,
  output logic       overrun,
  output logic [7:0] score
);

  localparam logic [8:0] SW9 = 9'(SPRITE_W);
  localparam logic [8:0] SH9 = 9'(SPRITE_H);

  state_t     state, state_nxt;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       walk_en, walk_done;
  logic [1:0] dx, dy;
  logic       collide, finish;
  logic [8:0] px9, py9, ox9, oy9;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Opposing or absent keys leave the row alone; clamp at both screen edges.
  function automatic logic [6:0] step_y(input logic [6:0] py, input logic up,
                                        input logic down);
    if (up && !down) return (py == 7'd0) ? py : py - 7'd1;
    if (down && !up) return (py >= Y_MAX) ? Y_MAX : py + 7'd1;
    return py;
  endfunction

  assign walk_en = (state == ST_INIT) || (state == ST_ERASE) || (state == ST_DRAW);

  sprite_walker u_walker (
    .clock(clock),
    .reset(reset),
    .start(walk_en),
    .dx   (dx),
    .dy   (dy),
    .done (walk_done)
  );

  assign px9 = {1'b0, pos_x};
  assign py9 = {2'b00, pos_y};
  assign ox9 = {1'b0, obs_x};
  assign oy9 = {2'b00, obs_y};

  assign collide = (px9 < ox9 + SW9) && (ox9 < px9 + SW9) &&
                   (py9 < oy9 + SH9) && (oy9 < py9 + SH9);
  assign finish  = (pos_x > X_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:  if (walk_done) state_nxt = ST_IDLE;
      ST_IDLE:  if (frame_tick) state_nxt = ST_ERASE;
      ST_ERASE: if (walk_done) state_nxt = ST_MOVE;
      ST_MOVE:  state_nxt = ST_DRAW;
      ST_DRAW:  if (walk_done) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (collide || finish) ? ST_OVER : ST_IDLE;
      ST_OVER:  state_nxt = ST_OVER;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Output stage: plot stream and busy lag the state register by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      won       <= 1'b0;
      overrun   <= 1'b0;
      score     <= '0;
      pos_x     <= START_X;
      pos_y     <= START_Y;
    end else begin
      plot <= walk_en;
      busy <= (state != ST_IDLE) && (state != ST_OVER);
      if (walk_en) begin
        x      <= pos_x + {6'd0, dx};
        y      <= pos_y + {5'd0, dy};
        colour <= (state == ST_ERASE) ? BG_COLOUR : PLAYER_COLOUR;
      end
      if (state == ST_MOVE) begin
        pos_x <= pos_x + 8'd1;
        pos_y <= step_y(pos_y, key_up, key_down);
      end
      if (state == ST_CHECK) begin
        if (collide) begin
          game_over <= 1'b1;
          won       <= 1'b0;
        end else begin
          score <= sat_inc8(score);
          if (finish) begin
            game_over <= 1'b1;
            won       <= 1'b1;
          end
        end
      end
      if (frame_tick && (state != ST_IDLE) && (state != ST_OVER)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_player_draw_ctrl.sv
// Randomized self-checking bench for player_draw_ctrl: a frame-level model
// predicts the pixel stream and status flags, literals pin key scenarios.
module tb_player_draw_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic [7:0] obs_x = 8'd200;
  logic [6:0] obs_y = 7'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, game_over, won, overrun;
  logic [7:0] score;

  player_draw_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .frame_tick(frame_tick),
    .key_up    (key_up),
    .key_down  (key_down),
    .obs_x     (obs_x),
    .obs_y     (obs_y),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .game_over (game_over),
    .won       (won),
    .overrun   (overrun),
    .score     (score)
  );

  always #5 clock = ~clock;

  typedef struct {
    int px;
    int py;
    int c;
  } pix_t;

  pix_t exp_q[$];
  pix_t cur;
  int   m_px, m_py, m_score;
  bit   m_over, m_won, m_overrun;
  int   n_pass = 0;
  int   n_chk = 0;
  int   first_erase_y, first_draw_x;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic void push_sprite(input int px, input int py, input int c);
    pix_t p;
    for (int k = 0; k < 16; k++) begin
      p.px = px + k % 4;
      p.py = py + k / 4;
      p.c  = c;
      exp_q.push_back(p);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_px      = 10;
    m_py      = 58;
    m_score   = 0;
    m_over    = 1'b0;
    m_won     = 1'b0;
    m_overrun = 1'b0;
    push_sprite(10, 58, 2);
  endfunction

  function automatic void model_frame(input bit up, input bit down);
    int  ox, oy;
    bit  hit;
    ox = int'(obs_x);
    oy = int'(obs_y);
    push_sprite(m_px, m_py, 0);
    m_px = m_px + 1;
    if (up && !down) m_py = (m_py > 0) ? m_py - 1 : 0;
    else if (down && !up) m_py = (m_py < 116) ? m_py + 1 : 116;
    push_sprite(m_px, m_py, 2);
    hit = (m_px < ox + 4) && (ox < m_px + 4) && (m_py < oy + 4) && (oy < m_py + 4);
    if (hit) begin
      m_over = 1'b1;
      m_won  = 1'b0;
    end else begin
      m_score = (m_score < 255) ? m_score + 1 : 255;
      if (m_px > 100) begin
        m_over = 1'b1;
        m_won  = 1'b1;
      end
    end
  endfunction

  // Every plotted pixel must be the next one the model predicts.
  always @(negedge clock) begin
    if (!reset && plot) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        check("pix_x", int'(x), cur.px);
        check("pix_y", int'(y), cur.py);
        check("pix_colour", int'(colour), cur.c);
      end
    end
  end

  task automatic do_reset();
    int bc;
    #2 reset = 1'b1;
    frame_tick = 1'b0;
    #1;
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_flags", int'({game_over, won, overrun}), 0);
    check("rst_score", int'(score), 0);
    model_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("init_first_plot", int'(plot), 1);
    check("init_first_x", int'(x), 10);
    check("init_first_y", int'(y), 58);
    check("init_colour", int'(colour), 2);
    bc = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      bc++;
      @(negedge clock);
    end
    check("init_busy_len", bc, 16);
    check("init_score", int'(score), 0);
    check("init_queue", exp_q.size(), 0);
  endtask

  task automatic do_frame(input bit up, input bit down, input bit mid, input bit rst_mid);
    int bc, first;
    if (m_over) begin
      @(posedge clock);
      #1 frame_tick = 1'b1;
      @(posedge clock);
      #1 frame_tick = 1'b0;
      bc = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (busy) bc++;
      end
      check("over_busy", bc, 0);
      check("over_flag", int'(game_over), 1);
      check("over_overrun", int'(overrun), int'(m_overrun));
      return;
    end
    model_frame(up, down);
    if (mid) m_overrun = 1'b1;
    key_up   = 1'($urandom_range(0, 1));
    key_down = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1 frame_tick = 1'b1;
    @(posedge clock);
    #1 frame_tick = 1'b0;
    bc    = 0;
    first = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (busy) begin
        bc++;
        if (first < 0) first = i;
      end else if (bc > 0) begin
        break;
      end
      if (i == 1) first_erase_y = int'(y);
      if (i == 18) first_draw_x = int'(x);
      if (i == 10) begin
        key_up   = up;
        key_down = down;
      end
      if (i == 20) begin
        key_up   = 1'($urandom_range(0, 1));
        key_down = 1'($urandom_range(0, 1));
      end
      if (mid && i == 23) frame_tick = 1'b1;
      if (mid && i == 24) frame_tick = 1'b0;
      if (rst_mid && i == 24) begin
        check("pre_reset_plot", int'(plot), 1);
        do_reset();
        return;
      end
    end
    check("frame_busy_len", bc, 34);
    check("frame_latency", first, 1);
    check("frame_queue", exp_q.size(), 0);
    check("score", int'(score), m_score);
    check("game_over", int'(game_over), int'(m_over));
    check("won", int'(won), int'(m_won));
    check("overrun", int'(overrun), int'(m_overrun));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    obs_x = 8'd200;
    obs_y = 7'd0;
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_first_draw_x", first_draw_x, 11);
    check("lit_first_erase_y", first_erase_y, 58);
    check("lit_score1", int'(score), 1);
    for (int f = 0; f < 60; f++) do_frame(1'b1, 1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check("lit_up_sat_y", first_erase_y, 0);
    do_frame(1'b1, 1'b1, 1'b0, 1'b0);
    check("lit_up_both_y", first_erase_y, 0);

    do_reset();
    for (int f = 0; f < 60; f++) do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check("lit_down_sat_y", first_erase_y, 116);
    do_frame(1'b1, 1'b1, 1'b1, 1'b0);
    check("lit_overrun", int'(overrun), 1);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_both_keys_y", first_erase_y, 116);
    for (int f = 0; f < 200 && !m_over; f++)
      do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check("lit_finish_score", int'(score), 91);
    check("lit_finish_won", int'(won), 1);
    check("lit_finish_over", int'(game_over), 1);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);

    do_reset();
    obs_x = 8'd14;
    obs_y = 7'd58;
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_coll_over", int'(game_over), 1);
    check("lit_coll_won", int'(won), 0);
    check("lit_coll_score", int'(score), 0);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 1'b0, 1'b0, 1'b0);

    obs_x = 8'd200;
    obs_y = 7'd0;
    do_reset();
    do_frame(1'b0, 1'b0, 1'b0, 1'b1);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      do_reset();
      obs_x = 8'($urandom_range(20, 140));
      obs_y = 7'($urandom_range(0, 116));
      for (int f = 0; f < 200 && !m_over; f++)
        do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 1'b0);
      do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
